gray_counter: RTL and testbench

//  Parametrised up/down Gray-code counter with registered binary and Gray outputs.

---
 rtl/gray_pkg.sv | 29 ++
 rtl/gray_counter_enc.sv | 13 +
 rtl/gray_counter.sv | 85 ++++++++
 tb/tb_gray_counter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the gray_counter slice.
// Values are carried in MAX_W-bit containers; callers cast down to their own width.
package gray_pkg;

   localparam int MAX_W = 32;

   function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] gray);
      logic [MAX_W-1:0] bin;
      bin[MAX_W-1] = gray[MAX_W-1];
      for (int i = MAX_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

   // All-ones value for a counter of the given width (2^width - 1).
   function automatic logic [MAX_W-1:0] max_val(input int width);
      return (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
   endfunction

   localparam int               DEF_WIDTH    = 4;
   localparam logic [MAX_W-1:0] DEF_MAX_VAL  = max_val(DEF_WIDTH);
   localparam logic [MAX_W-1:0] DEF_RST_GRAY = bin2gray('0);

endpackage

// File: rtl/gray_counter_enc.sv
// Combinational binary-to-Gray encoder, WIDTH bits in and out.
module gray_enc
   import gray_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray-code counter with registered binary and Gray outputs.
// Optional step checker enabled by defining GRAY_CNT_STEP_CHK_EN (adds step_err).
module gray_counter
   import gray_pkg::*;
#(
   parameter int                WIDTH   = 4,
   parameter bit                WRAP    = 1'b1,
   parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] bin_out,
   output logic [WIDTH-1:0] gray_out,
   output logic             tc
`ifdef GRAY_CNT_STEP_CHK_EN
   ,
   output logic             step_err
`endif
);

   localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(max_val(WIDTH));
   localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(MAX_W'(RST_VAL)));

   logic [WIDTH-1:0] bin_q;
   logic [WIDTH-1:0] gray_q;
   logic [WIDTH-1:0] bin_next;
   logic [WIDTH-1:0] gray_next;

   // NOTE: bin_next is assigned a default first so every path is covered and no latch is inferred.
   always_comb begin
      bin_next = bin_q;
      if (load) begin
         bin_next = load_val;
      end else if (en) begin
         if (up_dn) begin
            if (bin_q == MAX_VAL) bin_next = WRAP ? '0 : bin_q;
            else                  bin_next = bin_q + WIDTH'(1);
         end else begin
            if (bin_q == '0) bin_next = WRAP ? MAX_VAL : bin_q;
            else             bin_next = bin_q - WIDTH'(1);
         end
      end
   end

   // Encoding the next value keeps gray_out aligned with bin_out in the same cycle.
   gray_enc #(.WIDTH(WIDTH)) u_enc (
      .bin  (bin_next),
      .gray (gray_next)
   );

   // NOTE: registers use non-blocking assignments so all state updates see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q  <= RST_VAL;
         gray_q <= RST_GRAY;
      end else begin
         bin_q  <= bin_next;
         gray_q <= gray_next;
      end
   end

   assign bin_out  = bin_q;
   assign gray_out = gray_q;
   assign tc       = (up_dn && (bin_q == MAX_VAL)) || (!up_dn && (bin_q == '0));

`ifdef GRAY_CNT_STEP_CHK_EN
   logic [WIDTH-1:0] step_diff;

   assign step_diff = gray_q ^ gray_next;

   // Flags count steps that move more than one Gray bit; holds and loads are excluded.
   always_ff @(posedge clk) begin
      if (rst) begin
         step_err <= 1'b0;
      end else begin
         step_err <= en && !load && (step_diff != '0) && ($countones(step_diff) != 1);
      end
   end
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: a wrapping and a saturating instance, WIDTH=4.
module tb_gray_counter;

   logic       clk = 1'b0;
   logic       rst, en, up_dn, load;
   logic [3:0] load_val;
   logic [3:0] bin_w, gray_w, bin_s, gray_s;
   logic       tc_w, tc_s;
`ifdef GRAY_CNT_STEP_CHK_EN
   logic       step_err_w, step_err_s;
`endif

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   gray_counter #(.WIDTH(4), .WRAP(1'b1), .RST_VAL(4'd0)) dut_w (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .bin_out(bin_w), .gray_out(gray_w), .tc(tc_w)
`ifdef GRAY_CNT_STEP_CHK_EN
      , .step_err(step_err_w)
`endif
   );

   gray_counter #(.WIDTH(4), .WRAP(1'b0), .RST_VAL(4'd0)) dut_s (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .bin_out(bin_s), .gray_out(gray_s), .tc(tc_s)
`ifdef GRAY_CNT_STEP_CHK_EN
      , .step_err(step_err_s)
`endif
   );

   typedef struct packed {
      logic [3:0] bin;
      logic [3:0] gray;
      logic       tc;
   } exp_t;

   typedef struct {
      logic       rst, load, en, up;
      logic [3:0] lv;
      logic [3:0] bin, gray;
      logic       tc;
   } vec_t;

   exp_t       q_w[$];
   exp_t       q_s[$];
   logic [3:0] m_w, m_s;

   function automatic logic [3:0] g(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [3:0] m_next(input logic [3:0] b, input bit wrap, input logic r,
                                         input logic l, input logic e, input logic u,
                                         input logic [3:0] lv);
      if (r) return 4'd0;
      if (l) return lv;
      if (!e) return b;
      if (u) return (b == 4'd15) ? (wrap ? 4'd0 : 4'd15) : b + 4'd1;
      return (b == 4'd0) ? (wrap ? 4'd15 : 4'd0) : b - 4'd1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Drive one cycle, push model expectations, then pop and compare after the edge.
   task automatic drive(input logic r, input logic l, input logic e, input logic u,
                        input logic [3:0] lv);
      exp_t ew, es;
      rst = r; load = l; en = e; up_dn = u; load_val = lv;
      m_w = m_next(m_w, 1'b1, r, l, e, u, lv);
      m_s = m_next(m_s, 1'b0, r, l, e, u, lv);
      q_w.push_back('{bin: m_w, gray: g(m_w), tc: u ? (m_w == 4'd15) : (m_w == 4'd0)});
      q_s.push_back('{bin: m_s, gray: g(m_s), tc: u ? (m_s == 4'd15) : (m_s == 4'd0)});
      @(posedge clk);
      #1;
      ew = q_w.pop_front();
      es = q_s.pop_front();
      check("w.bin",  bin_w,  ew.bin);
      check("w.gray", gray_w, ew.gray);
      check("w.tc",   tc_w,   ew.tc);
      check("s.bin",  bin_s,  es.bin);
      check("s.gray", gray_s, es.gray);
      check("s.tc",   tc_s,   es.tc);
   endtask

   vec_t vecs[12];

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      logic [3:0] prev;

      rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
      m_w = 4'd0; m_s = 4'd0;

      // Reset for two cycles, then release and hold.
      drive(1, 0, 0, 1, 4'd0);
      drive(1, 0, 0, 1, 4'd0);
      drive(0, 0, 0, 1, 4'd0);
      check("rst.bin",  bin_w,  4'd0);
      check("rst.gray", gray_w, 4'b0000);
      check("rst.tc",   tc_w,   1'b0);

      // Sixteen up-steps: full Gray sequence then wrap; one bit changes per step.
      for (int i = 0; i < 16; i++) begin
         prev = gray_w;
         drive(0, 0, 1, 1, 4'd0);
         check("w.onebit", $countones(prev ^ gray_w), 1);
         if (i == 14) begin
            check("w.at15.gray", gray_w, 4'b1000);
            check("w.at15.tc",   tc_w,   1'b1);
         end
      end
      check("w.wrap.bin", bin_w, 4'd0);

      // Saturating instance holds at 15 while en stays high, then steps down.
      for (int i = 0; i < 3; i++) begin
         prev = gray_s;
         drive(0, 0, 1, 1, 4'd0);
         check("s.hold.nochange", prev ^ gray_s, 4'b0000);
      end
      check("s.hold.bin",  bin_s,  4'd15);
      check("s.hold.gray", gray_s, 4'b1000);
      check("s.hold.tc",   tc_s,   1'b1);
      drive(0, 0, 1, 0, 4'd0);
      check("s.down.bin",  bin_s,  4'd14);
      check("s.down.gray", gray_s, 4'b1001);

      // Load priority, down-wrap, reset priority; expectations for the wrapping instance.
      vecs[0]  = '{rst:0, load:1, en:1, up:1, lv:4'd7,  bin:4'd7,  gray:4'b0100, tc:0};
      vecs[1]  = '{rst:0, load:1, en:0, up:0, lv:4'd0,  bin:4'd0,  gray:4'b0000, tc:1};
      vecs[2]  = '{rst:0, load:0, en:1, up:0, lv:4'd3,  bin:4'd15, gray:4'b1000, tc:0};
      vecs[3]  = '{rst:0, load:0, en:1, up:1, lv:4'd3,  bin:4'd0,  gray:4'b0000, tc:0};
      vecs[4]  = '{rst:0, load:1, en:0, up:1, lv:4'd8,  bin:4'd8,  gray:4'b1100, tc:0};
      vecs[5]  = '{rst:0, load:0, en:1, up:1, lv:4'd0,  bin:4'd9,  gray:4'b1101, tc:0};
      vecs[6]  = '{rst:1, load:1, en:1, up:1, lv:4'd5,  bin:4'd0,  gray:4'b0000, tc:0};
      vecs[7]  = '{rst:0, load:0, en:0, up:0, lv:4'd5,  bin:4'd0,  gray:4'b0000, tc:1};
      vecs[8]  = '{rst:0, load:1, en:0, up:1, lv:4'd15, bin:4'd15, gray:4'b1000, tc:1};
      vecs[9]  = '{rst:0, load:0, en:1, up:1, lv:4'd0,  bin:4'd0,  gray:4'b0000, tc:0};
      vecs[10] = '{rst:0, load:0, en:1, up:0, lv:4'd0,  bin:4'd15, gray:4'b1000, tc:0};
      vecs[11] = '{rst:0, load:0, en:1, up:0, lv:4'd0,  bin:4'd14, gray:4'b1001, tc:0};
      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].lv);
         check("vec.bin",  bin_w,  vecs[i].bin);
         check("vec.gray", gray_w, vecs[i].gray);
         check("vec.tc",   tc_w,   vecs[i].tc);
      end

`ifdef GRAY_CNT_STEP_CHK_EN
      for (int i = 0; i < 32; i++) begin
         drive(0, 0, 1, (i < 20) ? 1'b1 : 1'b0, 4'd0);
         check("chk.quiet.w", step_err_w, 1'b0);
         check("chk.quiet.s", step_err_s, 1'b0);
      end
      drive(0, 1, 0, 1, 4'd0);
      // Corrupt the stored Gray value, then take one up-step from it.
      force dut_w.gray_q = 4'b0110;
      #1;
      release dut_w.gray_q;
      rst = 1'b0; load = 1'b0; en = 1'b1; up_dn = 1'b1;
      m_w = 4'd1; m_s = 4'd1;
      @(posedge clk);
      #1;
      check("chk.err.set",  step_err_w, 1'b1);
      check("chk.err.gray", gray_w,     4'b0001);
      en = 1'b0;
      @(posedge clk);
      #1;
      check("chk.err.clr",  step_err_w, 1'b0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
